control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired Moore control unit for the Mini SRC datapath.
- Sequences fetch, decode and execute by driving the register-select strobes (gra, grb, grc, rin, rout, BAout), Cout, the bus source/destination strobes, memory strobes and the ALU opcode from a T-state FSM.
- Sits between the IR and the register-select/encode logic, bus, ALU, and memory interface.

Parameters:
- OPC_W, 5, opcode width (ir[31:27]).
- ALU_OP_W, 5, width of alu_op output.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state RST.
- ir  in  32  instruction register contents.
- con_ff  in  1  branch condition flip-flop output.
- mem_ack  in  1  memory done; used only with MEM_HANDSHAKE_EN.
- ctrl  out  28  one-hot-per-bit control strobes, bit map in package.
- alu_op  out  5  ALU operation, valid in Zin cycles, else ALU_NOP.
- run  out  1  high except in RST and HALT.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Outputs are a pure decode of the state register (Moore). RST state: ctrl=0, alu_op=ALU_NOP, run=0, illegal_op=0.
- RST -> F0 unconditionally on the first clock after reset deasserts.
- Reset asserted in any state, mid-instruction included, returns to RST immediately; the partial instruction is abandoned.
- Fetch:
  - F0: PCout, MARin, IncPC, Zin.
  - F1: Zlowout, PCin, Read, MDRin.
  - F2: MDRout, IRin.
  - F2 -> T3 with branch on ir[31:27].
- Every instruction ends by returning to F0, except halt.
- Register ALU ops (add, sub, and, or, ror, rol, shr, shra, shl): T3 grb, rout, Yin; T4 grc, rout, Zin, alu_op; T5 Zlowout, gra, rin.
- Immediate ops (addi, andi, ori): as register ALU ops, but T4 uses Cout instead of grc, rout.
- ldi: T3 grb, BAout, Yin; T4 Cout, Zin, alu_op=ADD; T5 Zlowout, gra, rin.
- ld: T3 and T4 as ldi; T5 Zlowout, MARin; T6 Read, MDRin; T7 MDRout, gra, rin.
- st: T3 and T4 as ldi; T5 Zlowout, MARin; T6 gra, rout, MDRin; T7 Write.
- mul/div: T3 gra, rout, Yin; T4 grb, rout, Zin, alu_op; T5 Zlowout, LOin; T6 Zhighout, HIin.
- neg/not: T3 grb, rout, Zin, alu_op; T4 Zlowout, gra, rin.
- Branch:
  - T3 gra, rout, CONin; T4 PCout, Yin; T5 Cout, Zin, ADD.
  - T6: if con_ff, Zlowout and PCin; if not, no strobes.
  - con_ff is sampled in T6 only.
- jr: T3 gra, rout, PCin.
- jal: T3 PCout, LinkRin (writes R15); T4 gra, rout, PCin.
- Single-cycle moves, all in T3:
  - in: InPortout, gra, rin.
  - out: gra, rout, OutPortin.
  - mfhi: HIout, gra, rin.
  - mflo: LOout, gra, rin.
- nop: T3 with no strobes, then F0.
- halt: enters HALT; run=0, ctrl=0; only reset exits.
- Undefined opcode: a single T3 cycle with illegal_op=1, then F0 (treated as nop).
- Exactly one bus-source strobe is active per state, or none; this is a checked invariant.

Optional Feature:
- MEM_HANDSHAKE_EN defined: states F1, ld-T6 and st-T7 hold, with strobes held, until mem_ack=1, then advance. mem_ack in any other state is ignored.
- MEM_HANDSHAKE_EN undefined: memory is a fixed one cycle, mem_ack is unused, and state timing is exactly as listed above.

Decomposition:
- Package mini_src_pkg:
  - opcode localparams: ld=00000, ldi=00001, st=00010, add=00011, sub, and, or, ror, rol, shr, shra, shl, addi, andi, ori, div, mul, neg, not, br=10011, jr, jal, in, out, mfhi, mflo, nop=11010, halt=11011.
  - ALU_* op codes.
  - CTRL_* bit indices for ctrl.
  - state enum.
- Sub-module control_decode: combinational state -> {ctrl, alu_op, run, illegal_op}. The top module holds the state register and next-state logic.

Test Plan:
- Reset, then release: ctrl=0 and run=0 during reset; F0 strobes (PCout, MARin, IncPC, Zin) on the first clock after release.
- ir=add R1,R2,R3 (0x18918000): six cycles total.
  - T3 grb+rout+Yin; T4 grc+rout+Zin with alu_op=ALU_ADD; T5 gra+rin+Zlowout; then F0.
- ld R1,0x45(R2) (ir=0x00900045): MARin in T5, Read+MDRin in T6, gra+rin in T7. With MEM_HANDSHAKE_EN and mem_ack low for 3 cycles, T6 is held 4 cycles.
- br with con_ff=1 -> PCin asserted in T6; with con_ff=0 -> T6 has no strobes; both return to F0.
- ir opcode 11111 -> illegal_op pulses one cycle, then F0. halt -> run=0 and held for 20 cycles until reset.
- Assert reset during ld T5 -> state is RST within the same cycle, all strobes 0, fetch restarts at F0.

Source files
------------

// File: rtl/mini_src_pkg.sv
// mini_src_pkg: opcodes, ALU codes, control-strobe bit map and sequencer states for the Mini SRC control unit.
package mini_src_pkg;
  localparam int OPC_W = 5;
  localparam int ALU_OP_W = 5;
  localparam int CTRL_W = 28;
  localparam logic [OPC_W-1:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4,
    OP_AND = 5'd5, OP_OR = 5'd6, OP_ROR = 5'd7, OP_ROL = 5'd8, OP_SHR = 5'd9, OP_SHRA = 5'd10,
    OP_SHL = 5'd11, OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI = 5'd14, OP_DIV = 5'd15, OP_MUL = 5'd16,
    OP_NEG = 5'd17, OP_NOT = 5'd18, OP_BR = 5'd19, OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22,
    OP_OUT = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP = 5'd26, OP_HALT = 5'd27;
  localparam logic [ALU_OP_W-1:0] ALU_NOP = 5'd0, ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_AND = 5'd3,
    ALU_OR = 5'd4, ALU_ROR = 5'd5, ALU_ROL = 5'd6, ALU_SHR = 5'd7, ALU_SHRA = 5'd8, ALU_SHL = 5'd9,
    ALU_MUL = 5'd10, ALU_DIV = 5'd11, ALU_NEG = 5'd12, ALU_NOT = 5'd13;
  localparam int C_GRA = 0, C_GRB = 1, C_GRC = 2, C_RIN = 3, C_ROUT = 4, C_BAOUT = 5, C_COUT = 6,
    C_PCOUT = 7, C_MARIN = 8, C_INCPC = 9, C_ZIN = 10, C_ZLOWOUT = 11, C_ZHIGHOUT = 12, C_PCIN = 13,
    C_READ = 14, C_WRITE = 15, C_MDRIN = 16, C_MDROUT = 17, C_IRIN = 18, C_YIN = 19, C_CONIN = 20,
    C_LOIN = 21, C_HIIN = 22, C_LOOUT = 23, C_HIOUT = 24, C_LINKRIN = 25, C_INPORTOUT = 26,
    C_OUTPORTIN = 27;
  typedef enum logic [3:0] {RST, F0, F1, F2, T3, T4, T5, T6, T7, HALT} state_t;
  function automatic logic [CTRL_W-1:0] cb(input int i);
    return CTRL_W'(1) << i;
  endfunction
  localparam logic [CTRL_W-1:0] BUS_SRC = cb(C_ROUT) | cb(C_BAOUT) | cb(C_COUT) | cb(C_PCOUT) |
    cb(C_ZLOWOUT) | cb(C_ZHIGHOUT) | cb(C_MDROUT) | cb(C_LOOUT) | cb(C_HIOUT) | cb(C_INPORTOUT);
  // Final execute state of each instruction; undefined opcodes get a single T3.
  function automatic state_t last_t(input logic [OPC_W-1:0] op);
    return (op == OP_LD || op == OP_ST) ? T7
         : (op <= OP_ORI) ? T5
         : (op == OP_DIV || op == OP_MUL || op == OP_BR) ? T6
         : (op == OP_NEG || op == OP_NOT || op == OP_JAL) ? T4
         : T3;
  endfunction
  function automatic logic [ALU_OP_W-1:0] alu_of(input logic [OPC_W-1:0] op);
    case (op)
      OP_SUB: return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI: return ALU_OR;
      OP_ROR: return ALU_ROR;
      OP_ROL: return ALU_ROL;
      OP_SHR: return ALU_SHR;
      OP_SHRA: return ALU_SHRA;
      OP_SHL: return ALU_SHL;
      OP_MUL: return ALU_MUL;
      OP_DIV: return ALU_DIV;
      OP_NEG: return ALU_NEG;
      OP_NOT: return ALU_NOT;
      default: return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: IR/condition/memory inputs and control outputs of the Mini SRC sequencer.
interface control_sequencer_if;
  import mini_src_pkg::*;
  logic [31:0] ir;
  logic con_ff;
  logic mem_ack;
  logic [CTRL_W-1:0] ctrl;
  logic [ALU_OP_W-1:0] alu_op;
  logic run;
  logic illegal_op;
  modport master(input ir, con_ff, mem_ack, output ctrl, alu_op, run, illegal_op);
  modport slave(output ir, con_ff, mem_ack, input ctrl, alu_op, run, illegal_op);
endinterface

// File: rtl/control_sequencer_decode.sv
// control_decode: Moore output decode of sequencer state and latched opcode into control strobes.
module control_decode
  import mini_src_pkg::*;
(
  input  state_t st,
  input  logic [OPC_W-1:0] op,
  input  logic con_ff,
  output logic [CTRL_W-1:0] ctrl,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic run,
  output logic illegal_op
);
  localparam logic [CTRL_W-1:0] GRA_IN = cb(C_GRA) | cb(C_RIN);
  localparam logic [CTRL_W-1:0] GRA_OUT = cb(C_GRA) | cb(C_ROUT);
  localparam logic [CTRL_W-1:0] GRB_OUT = cb(C_GRB) | cb(C_ROUT);
  localparam logic [CTRL_W-1:0] GRC_OUT = cb(C_GRC) | cb(C_ROUT);
  logic alu_r, alu_i, mem, md, un;
  assign alu_r = op >= OP_ADD && op <= OP_SHL;
  assign alu_i = op >= OP_ADDI && op <= OP_ORI;
  assign mem = op <= OP_ST;
  assign md = op == OP_DIV || op == OP_MUL;
  assign un = op == OP_NEG || op == OP_NOT;
  assign run = st != RST && st != HALT;
  assign illegal_op = st == T3 && op > OP_HALT;
  // F0 loads Z through IncPC, so only execute-phase Zin cycles carry an ALU opcode.
  assign alu_op = ctrl[C_ZIN] && st != F0 ? alu_of(op) : ALU_NOP;
  always_comb begin
    ctrl = '0;
    case (st)
      F0: ctrl = cb(C_PCOUT) | cb(C_MARIN) | cb(C_INCPC) | cb(C_ZIN);
      F1: ctrl = cb(C_ZLOWOUT) | cb(C_PCIN) | cb(C_READ) | cb(C_MDRIN);
      F2: ctrl = cb(C_MDROUT) | cb(C_IRIN);
      T3: ctrl = alu_r || alu_i ? GRB_OUT | cb(C_YIN)
               : mem ? cb(C_GRB) | cb(C_BAOUT) | cb(C_YIN)
               : md ? GRA_OUT | cb(C_YIN)
               : un ? GRB_OUT | cb(C_ZIN)
               : op == OP_BR ? GRA_OUT | cb(C_CONIN)
               : op == OP_JR ? GRA_OUT | cb(C_PCIN)
               : op == OP_JAL ? cb(C_PCOUT) | cb(C_LINKRIN)
               : op == OP_IN ? cb(C_INPORTOUT) | GRA_IN
               : op == OP_OUT ? GRA_OUT | cb(C_OUTPORTIN)
               : op == OP_MFHI ? cb(C_HIOUT) | GRA_IN
               : op == OP_MFLO ? cb(C_LOOUT) | GRA_IN
               : '0;
      T4: ctrl = alu_r ? GRC_OUT | cb(C_ZIN)
               : alu_i || mem ? cb(C_COUT) | cb(C_ZIN)
               : md ? GRB_OUT | cb(C_ZIN)
               : un ? cb(C_ZLOWOUT) | GRA_IN
               : op == OP_BR ? cb(C_PCOUT) | cb(C_YIN)
               : op == OP_JAL ? GRA_OUT | cb(C_PCIN)
               : '0;
      T5: ctrl = alu_r || alu_i || op == OP_LDI ? cb(C_ZLOWOUT) | GRA_IN
               : op == OP_LD || op == OP_ST ? cb(C_ZLOWOUT) | cb(C_MARIN)
               : md ? cb(C_ZLOWOUT) | cb(C_LOIN)
               : op == OP_BR ? cb(C_COUT) | cb(C_ZIN)
               : '0;
      T6: ctrl = op == OP_LD ? cb(C_READ) | cb(C_MDRIN)
               : op == OP_ST ? GRA_OUT | cb(C_MDRIN)
               : md ? cb(C_ZHIGHOUT) | cb(C_HIIN)
               : op == OP_BR && con_ff ? cb(C_ZLOWOUT) | cb(C_PCIN)
               : '0;
      T7: ctrl = op == OP_LD ? cb(C_MDROUT) | GRA_IN
               : op == OP_ST ? cb(C_WRITE)
               : '0;
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore T-state sequencer for the Mini SRC datapath.
// MEM_HANDSHAKE_EN makes F1, ld-T6 and st-T7 wait for mem_ack; otherwise memory is one cycle.
module control_sequencer
  import mini_src_pkg::*;
(
  input logic clock,
  input logic reset,
  control_sequencer_if.master bus
);
  state_t st, nxt;
  logic [OPC_W-1:0] op;
  logic hold;
`ifdef MEM_HANDSHAKE_EN
  assign hold = !bus.mem_ack && (st == F1 || (st == T6 && op == OP_LD) || (st == T7 && op == OP_ST));
`else
  assign hold = 1'b0;
`endif
  // The opcode is captured alongside IRin so execute decode depends only on registers.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      st <= RST;
      op <= OP_NOP;
    end else begin
      st <= nxt;
      if (st == F2) op <= bus.ir[31:27];
    end
  always_comb begin
    nxt = st;
    if (!hold)
      nxt = st == RST ? F0
          : st == HALT ? HALT
          : st == F2 ? (bus.ir[31:27] == OP_HALT ? HALT : T3)
          : (st == F0 || st == F1 || st != last_t(op)) ? state_t'(st + 4'd1)
          : F0;
  end
  control_decode u_dec (
    .st(st),
    .op(op),
    .con_ff(bus.con_ff),
    .ctrl(bus.ctrl),
    .alu_op(bus.alu_op),
    .run(bus.run),
    .illegal_op(bus.illegal_op)
  );
  a_one_src: assert property (@(posedge clock) disable iff (reset) $onehot0(bus.ctrl & BUS_SRC));
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table vectors, randomized instruction stream against a sequence model, and reset/halt/handshake corners.
module tb_control_sequencer;
  import mini_src_pkg::*;
`ifdef MEM_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif
  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [ALU_OP_W-1:0] a;
    logic ill;
    logic hold;
    logic br6;
  } step_t;
  typedef struct {
    logic [OPC_W-1:0] op;
    logic cf;
    int cycles;
    int pcins;
    int ills;
  } vec_t;
  localparam logic [CTRL_W-1:0] FETCH0 = cb(C_PCOUT) | cb(C_MARIN) | cb(C_INCPC) | cb(C_ZIN);
  localparam logic [CTRL_W-1:0] FETCH1 = cb(C_ZLOWOUT) | cb(C_PCIN) | cb(C_READ) | cb(C_MDRIN);
  localparam logic [CTRL_W-1:0] FETCH2 = cb(C_MDROUT) | cb(C_IRIN);
  localparam logic [CTRL_W-1:0] RA_IN = cb(C_GRA) | cb(C_RIN);
  localparam logic [CTRL_W-1:0] RA_OUT = cb(C_GRA) | cb(C_ROUT);
  localparam logic [CTRL_W-1:0] RB_OUT = cb(C_GRB) | cb(C_ROUT);
  localparam logic [CTRL_W-1:0] ZLO = cb(C_ZLOWOUT);
  localparam logic [CTRL_W-1:0] ZI = cb(C_ZIN);
  localparam logic [CTRL_W-1:0] YI = cb(C_YIN);
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  step_t q[$];
  vec_t vt[15];
  control_sequencer_if bus();
  control_sequencer dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [ALU_OP_W-1:0] alu_ref(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB: return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI: return ALU_OR;
      OP_ROR: return ALU_ROR;
      OP_ROL: return ALU_ROL;
      OP_SHR: return ALU_SHR;
      OP_SHRA: return ALU_SHRA;
      OP_SHL: return ALU_SHL;
      OP_MUL: return ALU_MUL;
      OP_DIV: return ALU_DIV;
      OP_NEG: return ALU_NEG;
      OP_NOT: return ALU_NOT;
      default: return ALU_NOP;
    endcase
  endfunction
  task automatic put(input logic [CTRL_W-1:0] c, input logic [ALU_OP_W-1:0] a, input logic hold);
    step_t s;
    s.c = c;
    s.a = a;
    s.ill = 1'b0;
    s.hold = hold;
    s.br6 = 1'b0;
    q.push_back(s);
  endtask
  // Expected per-cycle strobes of one whole instruction, fetch included.
  task automatic build(input logic [OPC_W-1:0] op);
    logic [ALU_OP_W-1:0] a;
    a = alu_ref(op);
    q.delete();
    put(FETCH0, ALU_NOP, 1'b0);
    put(FETCH1, ALU_NOP, 1'b1);
    put(FETCH2, ALU_NOP, 1'b0);
    if (op >= OP_ADD && op <= OP_ORI) begin
      put(RB_OUT | YI, ALU_NOP, 1'b0);
      put((op <= OP_SHL ? cb(C_GRC) | cb(C_ROUT) : cb(C_COUT)) | ZI, a, 1'b0);
      put(ZLO | RA_IN, ALU_NOP, 1'b0);
    end else if (op <= OP_ST) begin
      put(cb(C_GRB) | cb(C_BAOUT) | YI, ALU_NOP, 1'b0);
      put(cb(C_COUT) | ZI, ALU_ADD, 1'b0);
      if (op == OP_LDI) put(ZLO | RA_IN, ALU_NOP, 1'b0);
      else begin
        put(ZLO | cb(C_MARIN), ALU_NOP, 1'b0);
        if (op == OP_LD) begin
          put(cb(C_READ) | cb(C_MDRIN), ALU_NOP, 1'b1);
          put(cb(C_MDROUT) | RA_IN, ALU_NOP, 1'b0);
        end else begin
          put(RA_OUT | cb(C_MDRIN), ALU_NOP, 1'b0);
          put(cb(C_WRITE), ALU_NOP, 1'b1);
        end
      end
    end else if (op == OP_DIV || op == OP_MUL) begin
      put(RA_OUT | YI, ALU_NOP, 1'b0);
      put(RB_OUT | ZI, a, 1'b0);
      put(ZLO | cb(C_LOIN), ALU_NOP, 1'b0);
      put(cb(C_ZHIGHOUT) | cb(C_HIIN), ALU_NOP, 1'b0);
    end else if (op == OP_NEG || op == OP_NOT) begin
      put(RB_OUT | ZI, a, 1'b0);
      put(ZLO | RA_IN, ALU_NOP, 1'b0);
    end else if (op == OP_BR) begin
      put(RA_OUT | cb(C_CONIN), ALU_NOP, 1'b0);
      put(cb(C_PCOUT) | YI, ALU_NOP, 1'b0);
      put(cb(C_COUT) | ZI, ALU_ADD, 1'b0);
      put('0, ALU_NOP, 1'b0);
      q[q.size()-1].br6 = 1'b1;
    end else if (op == OP_JR) put(RA_OUT | cb(C_PCIN), ALU_NOP, 1'b0);
    else if (op == OP_JAL) begin
      put(cb(C_PCOUT) | cb(C_LINKRIN), ALU_NOP, 1'b0);
      put(RA_OUT | cb(C_PCIN), ALU_NOP, 1'b0);
    end else if (op == OP_IN) put(cb(C_INPORTOUT) | RA_IN, ALU_NOP, 1'b0);
    else if (op == OP_OUT) put(RA_OUT | cb(C_OUTPORTIN), ALU_NOP, 1'b0);
    else if (op == OP_MFHI) put(cb(C_HIOUT) | RA_IN, ALU_NOP, 1'b0);
    else if (op == OP_MFLO) put(cb(C_LOOUT) | RA_IN, ALU_NOP, 1'b0);
    else begin
      put('0, ALU_NOP, 1'b0);
      q[q.size()-1].ill = op != OP_NOP;
    end
  endtask
  // All tasks start and end 1 time unit after a falling edge with the DUT in F0.
  task automatic run_model(input logic [OPC_W-1:0] op);
    int i = 0;
    int waits = 0;
    int guard = 0;
    logic [CTRL_W-1:0] e;
    string t;
    t = $sformatf("op%0d", op);
    build(op);
    bus.ir = {op, 27'($urandom)};
    while (i < q.size() && guard < 64) begin
      bus.con_ff = 1'($urandom);
      #1;
      e = q[i].br6 ? (bus.con_ff ? ZLO | cb(C_PCIN) : '0) : q[i].c;
      chk({t, " ctrl"}, 32'(bus.ctrl), 32'(e));
      chk({t, " alu_op"}, 32'(bus.alu_op), 32'(q[i].a));
      chk({t, " illegal_op"}, 32'(bus.illegal_op), 32'(q[i].ill));
      chk({t, " run"}, 32'(bus.run), 32'd1);
      chk({t, " bus sources"}, 32'($countones(bus.ctrl & BUS_SRC) <= 1), 32'd1);
      bus.mem_ack = waits < 4 ? 1'($urandom) : 1'b1;
      if (HS && q[i].hold && !bus.mem_ack) waits++;
      else begin
        i++;
        waits = 0;
      end
      guard++;
      @(negedge clock);
      #1;
    end
    chk({t, " sequence length"}, 32'(i), 32'(q.size()));
  endtask
  task automatic run_vec(input vec_t v);
    int cyc = 0;
    int pc = 0;
    int il = 0;
    string t;
    t = $sformatf("vec op%0d cf%0d", v.op, v.cf);
    bus.ir = {v.op, 27'h0};
    bus.con_ff = v.cf;
    bus.mem_ack = 1'b1;
    #1;
    do begin
      pc += int'(bus.ctrl[C_PCIN]);
      il += int'(bus.illegal_op);
      @(negedge clock);
      #1;
      cyc++;
    end while (bus.ctrl != FETCH0 && cyc < 20);
    chk({t, " cycles"}, 32'(cyc), 32'(v.cycles));
    chk({t, " pcin count"}, 32'(pc), 32'(v.pcins));
    chk({t, " illegal count"}, 32'(il), 32'(v.ills));
  endtask
  task automatic sync_f0();
    int n = 0;
    bus.mem_ack = 1'b1;
    while (bus.ctrl != FETCH0 && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("resync to F0", 32'(n < 20), 32'd1);
  endtask
  initial begin
    logic [OPC_W-1:0] op;
    logic [CTRL_W-1:0] e;
    vt = '{'{OP_ADD, 1'b0, 6, 1, 0}, '{OP_LD, 1'b0, 8, 1, 0}, '{OP_ST, 1'b0, 8, 1, 0},
           '{OP_LDI, 1'b0, 6, 1, 0}, '{OP_ORI, 1'b0, 6, 1, 0}, '{OP_MUL, 1'b0, 7, 1, 0},
           '{OP_NOT, 1'b0, 5, 1, 0}, '{OP_BR, 1'b1, 7, 2, 0}, '{OP_BR, 1'b0, 7, 1, 0},
           '{OP_JR, 1'b0, 4, 2, 0}, '{OP_JAL, 1'b0, 5, 2, 0}, '{OP_MFLO, 1'b0, 4, 1, 0},
           '{OP_NOP, 1'b0, 4, 1, 0}, '{5'd31, 1'b0, 4, 1, 1}, '{5'd28, 1'b0, 4, 1, 1}};
    bus.ir = 32'h18918000;
    bus.con_ff = 1'b0;
    bus.mem_ack = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("reset ctrl", 32'(bus.ctrl), 32'd0);
    chk("reset run", 32'(bus.run), 32'd0);
    chk("reset alu_op", 32'(bus.alu_op), 32'(ALU_NOP));
    chk("reset illegal_op", 32'(bus.illegal_op), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("first F0 ctrl", 32'(bus.ctrl), 32'(FETCH0));
    chk("first F0 run", 32'(bus.run), 32'd1);
    chk("first F0 alu_op", 32'(bus.alu_op), 32'(ALU_NOP));
    foreach (vt[i]) run_vec(vt[i]);
    for (int n = 0; n < 150; n++) begin
      do op = 5'($urandom_range(0, 31)); while (op == OP_HALT);
      run_model(op);
    end
    sync_f0();
    bus.ir = 32'h00900045;
    repeat (6) @(negedge clock);
    #1;
    chk("ld T6 ctrl", 32'(bus.ctrl), 32'(cb(C_READ) | cb(C_MDRIN)));
    bus.mem_ack = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      #1;
      e = HS ? (k < 4 ? cb(C_READ) | cb(C_MDRIN) : cb(C_MDROUT) | RA_IN)
             : (k == 1 ? cb(C_MDROUT) | RA_IN : k == 2 ? FETCH0 : k == 3 ? FETCH1 : FETCH2);
      chk($sformatf("ld mem wait cycle %0d", k), 32'(bus.ctrl), 32'(e));
      if (k == 3) bus.mem_ack = 1'b1;
    end
    sync_f0();
    bus.ir = 32'h00900045;
    repeat (5) @(negedge clock);
    #1;
    chk("ld T5 ctrl", 32'(bus.ctrl), 32'(ZLO | cb(C_MARIN)));
    #2 reset = 1'b1;
    #1;
    chk("mid-ld reset ctrl", 32'(bus.ctrl), 32'd0);
    chk("mid-ld reset run", 32'(bus.run), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("refetch after reset", 32'(bus.ctrl), 32'(FETCH0));
    bus.ir = {OP_HALT, 27'h0};
    repeat (3) @(negedge clock);
    #1;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("halt run %0d", k), 32'(bus.run), 32'd0);
      chk($sformatf("halt ctrl %0d", k), 32'(bus.ctrl), 32'd0);
      bus.mem_ack = 1'($urandom);
      bus.con_ff = 1'($urandom);
      @(negedge clock);
      #1;
    end
    reset = 1'b1;
    bus.ir = {OP_NOP, 27'h0};
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("F0 after halt reset", 32'(bus.ctrl), 32'(FETCH0));
    chk("run after halt reset", 32'(bus.run), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
